// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - three-floor elevator car controller (SCAN direction, travel and door timing)
//
// Purpose: takes the latched floor requests from the button block, picks a
// travel direction, times each one-floor step and the door dwell, and reports
// the car position back so the button block can clear served requests.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req1..req3   in   pending requests for floor codes 0..2 (level)
//   floor        out  current floor code (0..2)
//   move_handler out  high while travelling
//   dir_up       out  current/last travel direction, 1 = up
//   door_open    out  high while the door is open
module elevator_car_ctrl #(
    parameter int TRAVEL_TICKS = 50000000,
    parameter int DOOR_TICKS   = 100000000,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    output logic [1:0] floor,
    output logic       move_handler,
    output logic       dir_up,
    output logic       door_open
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MOVE = 2'b01,
        S_DOOR = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] L_TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] L_DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

    state_t           r_state, w_nxt_state;
    logic [1:0]       r_floor, w_nxt_floor;
    logic             r_dir_up, w_nxt_dir_up;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;

    logic [2:0] w_req;
    logic       w_above, w_below, w_here;
    logic [1:0] w_nf;
    logic       w_nf_here, w_nf_beyond;

    assign w_req = {req3, req2, req1};

    // Request position relative to the current floor.
    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        w_here  = 1'b0;
        case (r_floor)
            2'd0: begin w_above = w_req[1] | w_req[2]; w_here = w_req[0]; end
            2'd1: begin w_above = w_req[2]; w_below = w_req[0]; w_here = w_req[1]; end
            2'd2: begin w_below = w_req[0] | w_req[1]; w_here = w_req[2]; end
            default: ;
        endcase
    end

    // Floor reached at the end of the current step, and whether the
    // request set justifies continuing past it in the same direction.
    // Only the middle floor can have anything beyond it.
    assign w_nf = r_dir_up ? (r_floor + 2'd1) : (r_floor - 2'd1);

    always_comb begin
        w_nf_here   = 1'b0;
        w_nf_beyond = 1'b0;
        case (w_nf)
            2'd0: w_nf_here = w_req[0];
            2'd1: begin
                w_nf_here   = w_req[1];
                w_nf_beyond = r_dir_up ? w_req[2] : w_req[0];
            end
            2'd2: w_nf_here = w_req[2];
            default: ;
        endcase
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_floor  = r_floor;
        w_nxt_dir_up = r_dir_up;
        w_nxt_cnt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_nxt_cnt = '0;
                if (w_here) begin
                    w_nxt_state = S_DOOR;
                end else if (r_dir_up) begin
                    if (w_above) begin
                        w_nxt_state = S_MOVE;
                    end else if (w_below) begin
                        w_nxt_state  = S_MOVE;
                        w_nxt_dir_up = 1'b0;
                    end
                end else begin
                    if (w_below) begin
                        w_nxt_state = S_MOVE;
                    end else if (w_above) begin
                        w_nxt_state  = S_MOVE;
                        w_nxt_dir_up = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (r_cnt == L_TRAVEL_LAST) begin
                    w_nxt_cnt   = '0;
                    w_nxt_floor = w_nf;
                    if (w_nf_here) begin
                        w_nxt_state = S_DOOR;
                    end else if (w_nf_beyond) begin
                        w_nxt_state = S_MOVE;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_DOOR: begin
                if (r_cnt == L_DOOR_LAST) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_floor  <= 2'd0;
            r_dir_up <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_floor  <= w_nxt_floor;
            r_dir_up <= w_nxt_dir_up;
            r_cnt    <= w_nxt_cnt;
        end
    end

    assign floor        = r_floor;
    assign dir_up       = r_dir_up;
    assign move_handler = (r_state == S_MOVE);
    assign door_open    = (r_state == S_DOOR);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - self-checking bench for elevator_car_ctrl against a behavioural car model
module tb_elevator_car_ctrl;

    localparam int TT = 4;
    localparam int DT = 3;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [1:0] floor;
    logic       move_handler;
    logic       dir_up;
    logic       door_open;

    elevator_car_ctrl #(
        .TRAVEL_TICKS(TT),
        .DOOR_TICKS  (DT),
        .CNT_W       (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req1        (req[0]),
        .req2        (req[1]),
        .req3        (req[2]),
        .floor       (floor),
        .move_handler(move_handler),
        .dir_up      (dir_up),
        .door_open   (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural car: phase 0 idle, 1 travelling, 2 door open; timer counts
    // remaining cycles of the current step or dwell.
    int m_floor, m_up, m_phase, m_timer;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit wanted_beyond(input int f, input int up, input logic [2:0] r);
        for (int i = 0; i < 3; i++)
            if (r[i] && (up != 0 ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_up = 1; m_phase = 0; m_timer = 0;
    endtask

    task automatic model_edge(input logic [2:0] r);
        case (m_phase)
            0: begin
                if (r[m_floor]) begin
                    m_phase = 2; m_timer = DT;
                end else if (wanted_beyond(m_floor, m_up, r)) begin
                    m_phase = 1; m_timer = TT;
                end else if (wanted_beyond(m_floor, 1 - m_up, r)) begin
                    m_up = 1 - m_up; m_phase = 1; m_timer = TT;
                end
            end
            1: begin
                m_timer--;
                if (m_timer == 0) begin
                    m_floor = m_floor + (m_up != 0 ? 1 : -1);
                    if (r[m_floor]) begin
                        m_phase = 2; m_timer = DT;
                    end else if (wanted_beyond(m_floor, m_up, r)) begin
                        m_timer = TT;
                    end else begin
                        m_phase = 0;
                    end
                end
            end
            default: begin
                m_timer--;
                if (m_timer == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".floor"}, int'(floor), m_floor);
        check({tag, ".dir_up"}, int'(dir_up), m_up);
        check({tag, ".move"}, int'(move_handler), int'(m_phase == 1));
        check({tag, ".door"}, int'(door_open), int'(m_phase == 2));
    endtask

    // One clock: model follows the same edge, outputs checked on the falling
    // edge, then the button block clears the request at the reported floor.
    task automatic cycle(input string tag);
        logic [2:0] r_seen;
        r_seen = req;
        @(posedge clk);
        if (rst_n) model_edge(r_seen);
        @(negedge clk);
        compare_all(tag);
        req[m_floor] = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Asynchronous reset landing between clock edges.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".async_floor"}, int'(floor), 0);
        check({tag, ".async_dir"}, int'(dir_up), 1);
        check({tag, ".async_move"}, int'(move_handler), 0);
        check({tag, ".async_door"}, int'(door_open), 0);
        req = 3'b000;
        @(posedge clk);
        @(negedge clk);
        compare_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        model_reset();
        @(negedge clk);

        // 1: reset, then quiet for 10 cycles
        do_reset("t1");
        run("t1_idle", 10);
        check("t1.floor_after", int'(floor), 0);

        // 2: request at current floor
        req[0] = 1'b1;
        cycle("t2");
        check("t2.door_now", int'(door_open), 1);
        run("t2", 2);
        check("t2.door_last", int'(door_open), 1);
        cycle("t2");
        check("t2.door_closed", int'(door_open), 0);
        check("t2.no_move", int'(move_handler), 0);

        // 3: two-floor trip, no intermediate stop
        req[2] = 1'b1;
        cycle("t3");
        check("t3.moving", int'(move_handler), 1);
        run("t3", 4);
        check("t3.floor1", int'(floor), 1);
        check("t3.still_moving", int'(move_handler), 1);
        run("t3", 4);
        check("t3.floor2", int'(floor), 2);
        check("t3.door_at2", int'(door_open), 1);
        run("t3", 5);

        // 4: intermediate stop
        do_reset("t4");
        req[1] = 1'b1; req[2] = 1'b1;
        run("t4", 5);
        check("t4.floor1", int'(floor), 1);
        check("t4.door_at1", int'(door_open), 1);
        run("t4", 3);
        check("t4.idle_at1", int'(move_handler | door_open), 0);
        cycle("t4");
        check("t4.move_again", int'(move_handler), 1);
        run("t4", 4);
        check("t4.floor2", int'(floor), 2);
        check("t4.door_at2", int'(door_open), 1);
        run("t4", 4);

        // 5: reversal; start idle at floor 1
        do_reset("t5");
        req[1] = 1'b1;
        run("t5", 10);
        req[2] = 1'b1;
        run("t5", 3);
        req[0] = 1'b1;
        run("t5", 20);
        check("t5.floor0", int'(floor), 0);
        check("t5.dir_down", int'(dir_up), 0);

        // 6: reset mid-move at counter 2 going up from floor 1
        do_reset("t6");
        req[1] = 1'b1;
        run("t6", 10);
        req[2] = 1'b1;
        run("t6", 3);
        check("t6.moving_pre", int'(move_handler), 1);
        do_reset("t6");
        run("t6_after", 10);
        check("t6.floor_after", int'(floor), 0);

        // Random presses with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset("rnd_rst");
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 2)] = 1'b1;
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Car-side controller for the three-floor elevator. It is the other end of the button/request block.
- Consumes the three latched request lines (req1..req3), chooses a direction, and times travel between floors and door dwell.
- Drives `floor` and `move_handler` back to the button block. That block clears a request whenever `floor` equals its floor code.
- Floor codes: 2'b00 = floor 1, 2'b01 = floor 2, 2'b10 = floor 3. Code 2'b11 is never driven.

Parameters:
- TRAVEL_TICKS, 50000000: clock cycles spent in MOVE per one-floor step (minimum 2).
- DOOR_TICKS, 100000000: clock cycles the door stays open (minimum 2).
- CNT_W, 27: width of the shared tick counter. Must hold max(TRAVEL_TICKS, DOOR_TICKS) - 1.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req1  in  1  pending request for floor code 0 (active-high, level)
- req2  in  1  pending request for floor code 1
- req3  in  1  pending request for floor code 2
- floor  out  2  current car floor code
- move_handler  out  1  1 while the car is travelling (state MOVE)
- dir_up  out  1  current/last travel direction: 1 = up, 0 = down
- door_open  out  1  1 while in state DOOR

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, floor=2'b00, dir_up=1, move_handler=0, door_open=0, counter=0. Applies immediately, including mid-MOVE or mid-DOOR. Outputs are held while rst_n is low.
- Request vector r[2:0]={req3,req2,req1}.
  - above = any r bit with index > floor.
  - below = any r bit with index < floor.
  - here = r[floor].
  - At floor 2, above=0. At floor 0, below=0.
- All outputs are registered and decoded from state: move_handler=(state==MOVE), door_open=(state==DOOR).
- State IDLE, evaluated each edge in priority order:
  - here=1 -> DOOR, counter=0.
  - Else, if dir_up=1: above -> MOVE; else below -> MOVE with dir_up=0.
  - Else (dir_up=0): below -> MOVE; else above -> MOVE with dir_up=1.
  - No request: stay in IDLE.
  - Entry into MOVE clears the counter.
- State MOVE:
  - Counter increments each cycle.
  - At the edge where counter==TRAVEL_TICKS-1: floor <= floor+1 (dir_up) or floor-1, and counter=0.
  - The next-state decision at that same edge uses the request bit of the new floor, nf, sampled at that edge.
    - r[nf]=1 -> DOOR.
    - Else, further requests beyond nf in the current direction -> stay in MOVE for another step.
    - Else -> IDLE.
  - Net effect: floor changes exactly TRAVEL_TICKS cycles after MOVE is entered or after the previous step.
  - Requests asserted during travel are picked up at the next step decision.
- State DOOR:
  - Counter increments each cycle.
  - At the edge where counter==DOOR_TICKS-1: -> IDLE, counter=0.
  - door_open is therefore high for exactly DOOR_TICKS cycles.
  - The dwell is not extended by a new request at the same floor.
- Direction changes occur only in IDLE (SCAN policy): the car serves all requests in its current direction before reversing.
- Floor never leaves the 0..2 range. A step is only started when a request exists strictly beyond the current floor in the travel direction.
- Simultaneous requests above and below in IDLE: the current dir_up wins.
- All request inputs low throughout: car stays in IDLE indefinitely, outputs stable.

Test Plan (TRAVEL_TICKS=4, DOOR_TICKS=3):
1. Reset behaviour.
   - Stimulus: assert rst_n=0 asynchronously between edges, then release.
   - Required: floor=0, dir_up=1, move_handler=0, door_open=0 immediately and for 10 cycles after release with no requests.
2. Request at the current floor.
   - Stimulus: at floor 0 in IDLE, req1=1.
   - Required: next edge door_open=1 for exactly 3 cycles, then IDLE; move_handler stays 0.
3. Two-floor travel with no intermediate request.
   - Stimulus: at floor 0, req3=1 held until floor==2.
   - Required: move_handler=1 one edge later; floor=1 after 4 cycles without stopping; floor=2 after 8 cycles, same edge door_open=1; move_handler=0 during the 3 door cycles.
4. Intermediate stop.
   - Stimulus: at floor 0, req2=1 and req3=1 together.
   - Required: floor=1 with door 3 cycles; then IDLE, then MOVE up again; floor=2 four cycles later, door opens.
5. Reversal after serving the current direction.
   - Stimulus: at floor 1, car moving up to serve req3; req1 asserted mid-travel.
   - Required: car reaches floor 2 and opens door; then dir_up=0, moves down to floor 0 (4 cycles per step) and opens door.
6. Reset mid-move.
   - Stimulus: rst_n=0 during MOVE at counter=2 from floor 1 going up.
   - Required: immediately floor=0, move_handler=0, dir_up=1; no floor-2 arrival after release without a new request.
